// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and dispatch: in-order enqueue at tail,
// combinational issue from head, flush-to-empty, and a running head-blocked stall counter.
module instr_queue #(
   parameter int IQ_DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      fetch_valid,
   input  logic [31:0]               fetch_instr,
   input  logic [31:0]               fetch_pc,
   input  logic [31:0]               fetch_pc_next,
   input  logic                      fetch_pc_next_valid,
   input  logic                      rob_full,
   input  logic                      dispatch_stall,
   output logic                      iq_full,
   output logic                      iq_empty,
   output logic [$clog2(IQ_DEPTH):0] iq_count,
   output logic                      iq_issue,
   output logic [31:0]               iq_instr,
   output logic [31:0]               iq_pc,
   output logic [31:0]               iq_pc_next,
   output logic                      iq_pc_next_valid,
   output logic [31:0]               stall_count
);

   localparam int PW = $clog2(IQ_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_next;
      logic        pc_next_valid;
   } entry_t;

   entry_t                mem_q [IQ_DEPTH];
   logic [PW-1:0]         head_q, head_d;
   logic [PW-1:0]         tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   logic [IQ_DEPTH-1:0]   valid_q, valid_d;
   logic [31:0]           stall_q, stall_d;

   logic                  enq;
   logic                  blocked;
   logic                  head_live;
   entry_t                wr_entry;
   entry_t                head_entry;

   // Full/empty come straight from the registered count, never from this cycle's inputs.
   assign iq_full  = (count_q == CW'(IQ_DEPTH));
   assign iq_empty = (count_q == '0);
   assign iq_count = count_q;

   assign enq      = fetch_valid && !iq_full && !flush;
   assign iq_issue = !iq_empty && !rob_full && !dispatch_stall && !flush;
   assign blocked  = !iq_empty && !flush && (rob_full || dispatch_stall);

   assign wr_entry.instr         = fetch_instr;
   assign wr_entry.pc            = fetch_pc;
   assign wr_entry.pc_next       = fetch_pc_next;
   assign wr_entry.pc_next_valid = fetch_pc_next_valid;

   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[tail_q] <= wr_entry;
      end
   end

   // Per-entry valid bits; flush wipes them so a stale slot can never reach the head outputs.
   for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_valid
      assign valid_d[gi] = flush                                  ? 1'b0 :
                           (enq && (tail_q == PW'(gi)))           ? 1'b1 :
                           (iq_issue && (head_q == PW'(gi)))      ? 1'b0 :
                                                                    valid_q[gi];
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      stall_d = stall_q;
      if (blocked) begin
         stall_d = stall_q + 32'd1;
      end
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) begin
            tail_d = tail_q + PW'(1);
         end
         if (iq_issue) begin
            head_d = head_q + PW'(1);
         end
         case ({enq, iq_issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         stall_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         stall_q <= stall_d;
      end
   end

   assign head_entry = mem_q[head_q];
   assign head_live  = !iq_empty && valid_q[head_q];

   assign iq_instr         = head_live ? head_entry.instr         : 32'd0;
   assign iq_pc            = head_live ? head_entry.pc            : 32'd0;
   assign iq_pc_next       = head_live ? head_entry.pc_next       : 32'd0;
   assign iq_pc_next_valid = head_live ? head_entry.pc_next_valid : 1'b0;
   assign stall_count      = stall_q;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue (IQ_DEPTH=4): scoreboard of enqueued entries checked
// against head outputs each cycle, plus occupancy, flag, issue and stall-counter checks.
module tb_instr_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pc_next;
   logic        fetch_pc_next_valid;
   logic        rob_full;
   logic        dispatch_stall;
   logic        iq_full;
   logic        iq_empty;
   logic [2:0]  iq_count;
   logic        iq_issue;
   logic [31:0] iq_instr;
   logic [31:0] iq_pc;
   logic [31:0] iq_pc_next;
   logic        iq_pc_next_valid;
   logic [31:0] stall_count;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_next;
      logic        pnv;
   } sb_t;

   sb_t         sb_q[$];
   int          mdl_cnt;
   logic [31:0] mdl_stall;
   int          checks;
   int          errors;

   instr_queue #(.IQ_DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .fetch_valid         (fetch_valid),
      .fetch_instr         (fetch_instr),
      .fetch_pc            (fetch_pc),
      .fetch_pc_next       (fetch_pc_next),
      .fetch_pc_next_valid (fetch_pc_next_valid),
      .rob_full            (rob_full),
      .dispatch_stall      (dispatch_stall),
      .iq_full             (iq_full),
      .iq_empty            (iq_empty),
      .iq_count            (iq_count),
      .iq_issue            (iq_issue),
      .iq_instr            (iq_instr),
      .iq_pc               (iq_pc),
      .iq_pc_next          (iq_pc_next),
      .iq_pc_next_valid    (iq_pc_next_valid),
      .stall_count         (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive, check settled outputs against the model, advance model, clock.
   task automatic do_cycle(input logic fv, input logic [31:0] pc, input logic rf,
                           input logic ds, input logic fl);
      sb_t  e;
      sb_t  h;
      logic exp_issue;
      e.pc      = pc;
      e.instr   = pc ^ 32'hA5A5_0000;
      e.pc_next = pc + 32'h10;
      e.pnv     = pc[2];
      fetch_valid         = fv;
      fetch_pc            = e.pc;
      fetch_instr         = e.instr;
      fetch_pc_next       = e.pc_next;
      fetch_pc_next_valid = e.pnv;
      rob_full            = rf;
      dispatch_stall      = ds;
      flush               = fl;
      #1;
      exp_issue = (mdl_cnt != 0) && !rf && !ds && !fl;
      check("iq_count",    32'(iq_count),    32'(mdl_cnt));
      check("iq_empty",    32'(iq_empty),    32'(mdl_cnt == 0));
      check("iq_full",     32'(iq_full),     32'(mdl_cnt == DEPTH));
      check("iq_issue",    32'(iq_issue),    32'(exp_issue));
      check("stall_count", stall_count,      mdl_stall);
      if (mdl_cnt != 0) begin
         h = sb_q[0];
         check("iq_pc",            iq_pc,                   h.pc);
         check("iq_instr",         iq_instr,                h.instr);
         check("iq_pc_next",       iq_pc_next,              h.pc_next);
         check("iq_pc_next_valid", 32'(iq_pc_next_valid),   32'(h.pnv));
         if (exp_issue) $display("issue pc=0x%08h count=%0d", iq_pc, iq_count);
      end else begin
         check("empty_pc",        iq_pc,                    32'd0);
         check("empty_instr",     iq_instr,                 32'd0);
         check("empty_pc_next",   iq_pc_next,               32'd0);
         check("empty_pnv",       32'(iq_pc_next_valid),    32'd0);
      end
      if (!fl && (mdl_cnt != 0) && (rf || ds)) mdl_stall = mdl_stall + 32'd1;
      if (fl) begin
         sb_q.delete();
      end else begin
         if (exp_issue) void'(sb_q.pop_front());
         if (fv && (mdl_cnt != DEPTH)) sb_q.push_back(e);
      end
      mdl_cnt = sb_q.size();
      @(posedge clk);
      #1;
   endtask

   // Reset cycle with enqueue/flush requests presented; none of them may take effect.
   task automatic do_reset();
      rst                 = 1'b1;
      fetch_valid         = 1'b1;
      fetch_pc            = 32'hDEAD_0000;
      fetch_instr         = 32'hDEAD_BEEF;
      fetch_pc_next       = 32'hDEAD_0004;
      fetch_pc_next_valid = 1'b1;
      rob_full            = 1'b0;
      dispatch_stall      = 1'b0;
      flush               = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      mdl_cnt   = 0;
      mdl_stall = 32'd0;
      $display("reset");
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      mdl_cnt   = 0;
      mdl_stall = 32'd0;
      rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
      fetch_pc_next = '0; fetch_pc_next_valid = 1'b0; rob_full = 1'b0; dispatch_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Fill with rob_full: fifth fetch refused, stall_count reaches 3 after edge 4.
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      // Drain in order.
      for (int i = 0; i < 5; i++) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Move head to 3, then hold count 2 across the 3->0 wrap with enqueue+issue.
      do_cycle(1'b1, 32'h1100, 1'b1, 1'b0, 1'b0);
      do_cycle(1'b1, 32'h1104, 1'b0, 1'b1, 1'b0);
      do_cycle(1'b1, 32'h1108, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b1, 32'h1200, 1'b1, 1'b0, 1'b0);
      do_cycle(1'b1, 32'h1204, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h1208 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Flush with a concurrent fetch at count 3.
      for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h1300 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      do_cycle(1'b1, 32'h1310, 1'b0, 1'b0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Empty queue: no fetch-to-issue bypass.
      do_cycle(1'b1, 32'h2000, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Reset mid-operation: count 3, stall_count 7.
      do_reset();
      for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h2100 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("stall_before_reset", stall_count, 32'd7);
      check("count_before_reset", 32'(iq_count), 32'd3);
      do_reset();
      check("rst_count", 32'(iq_count),    32'd0);
      check("rst_stall", stall_count,      32'd0);
      check("rst_empty", 32'(iq_empty),    32'd1);
      do_cycle(1'b1, 32'h3000, 1'b1, 1'b0, 1'b0);
      check("entry0_pc", dut.mem_q[0].pc, 32'h3000);
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter IQ_DEPTH, default 16, SHALL be the number of entries and SHALL be a power of two, at least 2.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  pipeline flush from commit; discards all queued entries.
REQ-005 fetch_valid  input  1  fetch presents an instruction this cycle.
REQ-006 fetch_instr  input  32  instruction word.
REQ-007 fetch_pc  input  32  PC of the instruction.
REQ-008 fetch_pc_next  input  32  predicted next PC.
REQ-009 fetch_pc_next_valid  input  1  the prediction is valid.
REQ-010 rob_full  input  1  ROB cannot accept an entry.
REQ-011 dispatch_stall  input  1  a reservation station or other downstream resource cannot accept an entry.
REQ-012 iq_full  output  1  queue holds IQ_DEPTH entries; fetch SHALL hold its entry while this is high.
REQ-013 iq_empty  output  1  queue holds 0 entries.
REQ-014 iq_count  output  $clog2(IQ_DEPTH)+1  current occupancy.
REQ-015 iq_issue  output  1  the head entry is dispatched to decode, ROB and RS this cycle.
REQ-016 iq_instr, iq_pc, iq_pc_next  output  32 each  head entry fields.
REQ-017 iq_pc_next_valid  output  1  head entry prediction-valid bit.
REQ-018 stall_count  output  32  number of cycles the head was valid but blocked.

Function
REQ-019 Storage SHALL be a circular buffer with head and tail pointers of width $clog2(IQ_DEPTH) and a separate occupancy counter; the pointers SHALL wrap from IQ_DEPTH-1 to 0.
REQ-020 Enqueue SHALL occur when fetch_valid && !iq_full && !flush, writing all four fetch fields at tail; tail SHALL then increment.
REQ-021 iq_issue SHALL equal !iq_empty && !rob_full && !dispatch_stall && !flush, evaluated combinationally in the same cycle.
REQ-022 On iq_issue, head SHALL increment at the clock edge.
REQ-023 iq_full SHALL be (iq_count == IQ_DEPTH); iq_empty SHALL be (iq_count == 0); both SHALL derive from registered state only.
REQ-024 Simultaneous enqueue and issue SHALL leave iq_count unchanged, with both pointers advancing.
REQ-025 When the queue is full, enqueue SHALL be refused even if issue occurs in the same cycle; no full-queue bypass.
REQ-026 When the queue is empty, there SHALL be no fetch-to-issue bypass: an entry enqueued at edge N SHALL first be issuable in cycle N+1, a minimum latency of 1 cycle.
REQ-027 Head fields SHALL be driven from the storage at head; when iq_empty=1 all head data outputs SHALL be 0.
REQ-028 Flush SHALL take priority over enqueue and issue: in the flush cycle iq_issue=0 and no write occurs; at the next edge head, tail and iq_count SHALL become 0.
REQ-029 The valid bits of all entries SHALL be cleared on flush, so stale data is never issued.
REQ-030 stall_count SHALL increment by 1 on every cycle with !iq_empty && !flush && (rob_full || dispatch_stall); it SHALL wrap modulo 2^32 and SHALL not clear on flush.
REQ-031 iq_count SHALL never exceed IQ_DEPTH or go below 0 under any input combination.

Reset
REQ-032 While rst=1 at an edge, head, tail, iq_count, all entry valid bits and stall_count SHALL be cleared to 0.
REQ-033 After reset, outputs SHALL be iq_empty=1, iq_full=0, iq_count=0, iq_issue=0, and all head data outputs 0.
REQ-034 Reset SHALL override flush, enqueue and issue in the same cycle.
REQ-035 An enqueue or issue presented during a reset cycle SHALL have no effect.

Verification (bench with IQ_DEPTH=4)
REQ-036 Fill: 5 consecutive fetch_valid with pc 0x1000..0x1010, rob_full=1 -> iq_count=4 and iq_full=1 after 4 edges; the 0x1010 entry is refused; stall_count=3 after the fourth edge.
REQ-037 Drain: then rob_full=0 with fetch idle -> iq_issue high for 4 cycles with iq_pc 0x1000, 0x1004, 0x1008, 0x100C, then iq_empty=1.
REQ-038 Wrap and simultaneous events: count=2 with head=3, enqueue and issue for 3 cycles -> count stays 2; order is preserved across the 3->0 wrap.
REQ-039 Flush: count=3 with flush=1 and fetch_valid=1 in the same cycle -> iq_issue=0 that cycle; next cycle iq_count=0, iq_empty=1 and data outputs 0.
REQ-040 Latency: empty queue, enqueue pc 0x2000 at edge N -> iq_issue=0 in cycle N and iq_issue=1 with iq_pc=0x2000 in cycle N+1.
REQ-041 Reset mid-operation: count=3 with stall_count=7, assert rst for 1 cycle -> all counters 0, iq_empty=1; the next enqueue lands at entry 0.
